mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder serving one icache port and one dcache
// port from internal word storage, with a fixed LAT-cycle access delay.
// Define MEM_RESPONDER_STATS_EN to add saturating rd_count/wr_count outputs.

module mem_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  LAT_LAST = 4'((LAT == 0) ? 0 : LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic [3:0]      r_cnt, w_cnt_n;
  logic            r_sel_d, w_sel_d_n;
  logic            r_wr, w_wr_n;
  logic [AW-1:0]   r_idx, w_idx_n;
  logic [31:0]     r_wdata, w_wdata_n;
  logic            r_iwait, r_dwait;
  logic [31:0]     r_iload, r_dload;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req_d;
  logic            w_active;
  logic            w_done_n;
  logic            w_load_en;
  logic            w_unused;

  // Byte-offset and above-DEPTH address bits do not select storage.
  assign w_unused = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};

  assign w_req_d   = dREN | dWEN;
  assign w_active  = r_sel_d ? w_req_d : iREN;
  assign w_done_n  = (w_state_n == DONE);
  assign w_load_en = w_done_n & ~w_wr_n;

  assign iwait = r_iwait;
  assign dwait = r_dwait;
  assign iload = r_iload;
  assign dload = r_dload;

  // Next-state: latch request in IDLE (data port wins), count LAT, abort on drop.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_sel_d_n = r_sel_d;
    w_wr_n    = r_wr;
    w_idx_n   = r_idx;
    w_wdata_n = r_wdata;
    case (r_state)
      IDLE: begin
        w_cnt_n = 4'd0;
        if (w_req_d || iREN) begin
          w_sel_d_n = w_req_d;
          w_wr_n    = w_req_d & dWEN;
          w_idx_n   = w_req_d ? daddr[AW+1:2] : iaddr[AW+1:2];
          w_wdata_n = dstore;
          w_state_n = (LAT == 0) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (!w_active) begin
          w_state_n = IDLE;
          w_cnt_n   = 4'd0;
        end else if (r_cnt == LAT_LAST) begin
          w_state_n = DONE;
          w_cnt_n   = 4'd0;
        end else begin
          w_cnt_n = r_cnt + 4'd1;
        end
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // State, latched request and registered wait flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_sel_d <= 1'b0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_iwait <= 1'b1;
      r_dwait <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sel_d <= w_sel_d_n;
      r_wr    <= w_wr_n;
      r_idx   <= w_idx_n;
      r_wdata <= w_wdata_n;
      r_iwait <= ~(w_done_n & ~w_sel_d_n);
      r_dwait <= ~(w_done_n & w_sel_d_n);
    end
  end

  // Read data is captured on the edge entering DONE and held until the next read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_iload <= 32'd0;
      r_dload <= 32'd0;
    end else if (w_load_en) begin
      if (w_sel_d_n) r_dload <= r_mem[w_idx_n];
      else           r_iload <= r_mem[w_idx_n];
    end
  end

  // Writes commit at the edge leaving DONE; storage is never reset.
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == DONE) && r_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] r_rd_count, r_wr_count;

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  // Saturating completion counters, bumped as each DONE cycle ends.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (r_state == DONE) begin
      if (r_wr) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end
`endif

endmodule
